// File: rtl/regfile_arb_pkg.sv
// regfile_arb_pkg: shared widths and request/response records for the register file port arbiter
package regfile_arb_pkg;
    localparam int RF_ADDR_W  = 4;
    localparam int RF_DATA_W  = 32;
    localparam int RF_NUM_REQ = 4;
    typedef struct packed {
        logic [1:0]           read_en;
        logic [RF_ADDR_W-1:0] raddr_0;
        logic [RF_ADDR_W-1:0] raddr_1;
        logic                 write_en;
        logic [RF_ADDR_W-1:0] waddr;
        logic [RF_DATA_W-1:0] wdata;
    } rf_req_t;
    typedef struct packed {
        logic                 valid;
        logic [RF_DATA_W-1:0] rdata_0;
        logic [RF_DATA_W-1:0] rdata_1;
    } rf_rsp_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: one-hot grant to the first valid requester at or above the pointer, wrapping around
module rr_arbiter #(
    parameter int  NUM_REQ = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_valid,
    input  logic [ID_W-1:0]    i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [ID_W-1:0]    o_idx,
    output logic               o_any
);
    logic [NUM_REQ-1:0] w_rot;
    logic [ID_W-1:0]    w_off;
    logic [ID_W:0]      w_sum;
    // rotate so the pointer position lands at bit 0, then take the lowest set bit
    assign w_rot = NUM_REQ'({i_valid, i_valid} >> i_ptr);
    always_comb begin
        w_off = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) w_off = w_rot[k] ? ID_W'(k) : w_off;
    end
    assign w_sum   = {1'b0, i_ptr} + {1'b0, w_off};
    assign o_any   = |i_valid;
    assign o_idx   = !o_any ? '0 :
                     w_sum >= (ID_W+1)'(NUM_REQ) ? ID_W'(w_sum - (ID_W+1)'(NUM_REQ)) : w_sum[ID_W-1:0];
    assign o_grant = o_any ? NUM_REQ'(1) << o_idx : '0;
endmodule

// File: rtl/regfile_port_arbiter.sv
// regfile_port_arbiter: round-robin owner of the register file ports with a registered read response.
// Define RF_ARB_FWD_EN to return the granted request's own write data on a same-address read.
module regfile_port_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int  NUM_REQ = RF_NUM_REQ,
    parameter int  ADDR_W  = RF_ADDR_W,
    parameter int  DATA_W  = RF_DATA_W,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [2*NUM_REQ-1:0]      req_read_en,
    input  logic [ADDR_W*NUM_REQ-1:0] req_raddr_0,
    input  logic [ADDR_W*NUM_REQ-1:0] req_raddr_1,
    input  logic [NUM_REQ-1:0]        req_write_en,
    input  logic [ADDR_W*NUM_REQ-1:0] req_waddr,
    input  logic [DATA_W*NUM_REQ-1:0] req_wdata,
    output logic                      rsp_valid,
    output logic [ID_W-1:0]           rsp_id,
    output logic [DATA_W-1:0]         rsp_rdata_0,
    output logic [DATA_W-1:0]         rsp_rdata_1,
    output logic [1:0]                rf_read_en,
    output logic [ADDR_W-1:0]         rf_raddr_0,
    output logic [ADDR_W-1:0]         rf_raddr_1,
    output logic                      rf_write_en,
    output logic [ADDR_W-1:0]         rf_waddr,
    output logic [DATA_W-1:0]         rf_wdata,
    input  logic [DATA_W-1:0]         rf_rdata_0,
    input  logic [DATA_W-1:0]         rf_rdata_1
);
    logic [NUM_REQ-1:0] w_valid;
    logic [NUM_REQ-1:0] w_grant;
    logic [ID_W-1:0]    w_idx;
    logic               w_any;
    logic [ID_W-1:0]    r_ptr;
    logic [ID_W-1:0]    r_rsp_id;
    rf_req_t            w_req [NUM_REQ];
    rf_req_t            w_sel;
    rf_rsp_t            r_rsp;
    logic               w_hit_0;
    logic               w_hit_1;
    logic [DATA_W-1:0]  w_rd_0;
    logic [DATA_W-1:0]  w_rd_1;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
        assign w_req[i] = '{read_en:  req_read_en[2*i +: 2],
                            raddr_0:  req_raddr_0[ADDR_W*i +: ADDR_W],
                            raddr_1:  req_raddr_1[ADDR_W*i +: ADDR_W],
                            write_en: req_write_en[i],
                            waddr:    req_waddr[ADDR_W*i +: ADDR_W],
                            wdata:    req_wdata[DATA_W*i +: DATA_W]};
    end

    // masking valids during reset keeps grants and register file writes off
    assign w_valid = reset_n ? req_valid : '0;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .i_valid (w_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    assign req_ready   = w_grant;
    assign w_sel       = w_any ? w_req[w_idx] : '0;
    assign rf_read_en  = w_sel.read_en;
    assign rf_raddr_0  = w_sel.raddr_0;
    assign rf_raddr_1  = w_sel.raddr_1;
    assign rf_write_en = w_sel.write_en;
    assign rf_waddr    = w_sel.waddr;
    assign rf_wdata    = w_sel.wdata;

`ifdef RF_ARB_FWD_EN
    assign w_hit_0 = w_sel.write_en && w_sel.waddr == w_sel.raddr_0;
    assign w_hit_1 = w_sel.write_en && w_sel.waddr == w_sel.raddr_1;
`else
    assign w_hit_0 = 1'b0;
    assign w_hit_1 = 1'b0;
`endif

    assign w_rd_0 = !w_sel.read_en[0] ? '0 : w_hit_0 ? w_sel.wdata : rf_rdata_0;
    assign w_rd_1 = !w_sel.read_en[1] ? '0 : w_hit_1 ? w_sel.wdata : rf_rdata_1;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_ptr    <= '0;
            r_rsp    <= '0;
            r_rsp_id <= '0;
        end else begin
            if (w_any) r_ptr <= w_idx == ID_W'(NUM_REQ - 1) ? '0 : w_idx + 1'b1;
            r_rsp    <= '{valid: w_any, rdata_0: w_rd_0, rdata_1: w_rd_1};
            r_rsp_id <= w_idx;
        end
    end

    assign rsp_valid   = r_rsp.valid;
    assign rsp_id      = r_rsp_id;
    assign rsp_rdata_0 = r_rsp.rdata_0;
    assign rsp_rdata_1 = r_rsp.rdata_1;
endmodule

// File: tb/tb_regfile_port_arbiter.sv
// tb_regfile_port_arbiter: directed vector table plus hand sequences against a behavioural register file
module tb_regfile_port_arbiter;
    logic         clk = 1'b0;
    logic         reset_n;
    logic         clr;
    logic [3:0]   req_valid, req_ready, req_write_en;
    logic [7:0]   req_read_en;
    logic [15:0]  req_raddr_0, req_raddr_1, req_waddr;
    logic [127:0] req_wdata;
    logic         rsp_valid;
    logic [1:0]   rsp_id;
    logic [31:0]  rsp_rdata_0, rsp_rdata_1;
    logic [1:0]   rf_read_en;
    logic [3:0]   rf_raddr_0, rf_raddr_1, rf_waddr;
    logic         rf_write_en;
    logic [31:0]  rf_wdata, rf_rdata_0, rf_rdata_1;
    logic [31:0]  mem [16];
    int           n_tests = 0;
    int           n_fail  = 0;

`ifdef RF_ARB_FWD_EN
    localparam logic [31:0] FWD = 32'h1234_5678;
`else
    localparam logic [31:0] FWD = 32'h0;
`endif

    typedef struct {
        logic [3:0]  v;
        logic [1:0]  rd;
        logic [3:0]  ra0, ra1;
        logic        we;
        logic [3:0]  wa;
        logic [31:0] wd;
        logic [3:0]  ready;
        logic        rv;
        logic [1:0]  id;
        logic [31:0] d0, d1;
    } vec_t;

    vec_t tbl[$];

    always #5 clk = ~clk;

    always @(posedge clk)
        if (clr) for (int i = 0; i < 16; i++) mem[i] <= '0;
        else if (rf_write_en) mem[rf_waddr] <= rf_wdata;

    assign rf_rdata_0 = mem[rf_raddr_0];
    assign rf_rdata_1 = mem[rf_raddr_1];

    regfile_port_arbiter dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_read_en(req_read_en),
        .req_raddr_0(req_raddr_0), .req_raddr_1(req_raddr_1),
        .req_write_en(req_write_en), .req_waddr(req_waddr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_rdata_0(rsp_rdata_0), .rsp_rdata_1(rsp_rdata_1),
        .rf_read_en(rf_read_en), .rf_raddr_0(rf_raddr_0), .rf_raddr_1(rf_raddr_1),
        .rf_write_en(rf_write_en), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .rf_rdata_0(rf_rdata_0), .rf_rdata_1(rf_rdata_1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] v, input logic [1:0] rd, input logic [3:0] ra0, input logic [3:0] ra1,
                         input logic we, input logic [3:0] wa, input logic [31:0] wd);
        req_valid    = v;
        req_read_en  = {4{rd}};
        req_raddr_0  = {4{ra0}};
        req_raddr_1  = {4{ra1}};
        req_write_en = {4{we}};
        req_waddr    = {4{wa}};
        req_wdata    = {4{wd}};
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic [3:0] v, input logic [1:0] rd, input logic [3:0] ra0, input logic [3:0] ra1,
                                input logic we, input logic [3:0] wa, input logic [31:0] wd, input logic [3:0] ready,
                                input logic rv, input logic [1:0] id, input logic [31:0] d0, input logic [31:0] d1);
        vec_t t;
        t.v = v; t.rd = rd; t.ra0 = ra0; t.ra1 = ra1; t.we = we; t.wa = wa; t.wd = wd;
        t.ready = ready; t.rv = rv; t.id = id; t.d0 = d0; t.d1 = d1;
        return t;
    endfunction

    initial begin
        for (int k = 0; k < 8; k++)
            tbl.push_back(mk(4'hF, 2'b00, 4'h0, 4'h0, 1'b0, 4'h0, 32'h0, 4'(1 << (k % 4)), 1'b1, 2'(k % 4), 32'h0, 32'h0));
        for (int k = 0; k < 3; k++)
            tbl.push_back(mk(4'b0010, 2'b00, 4'h0, 4'h0, 1'b0, 4'h0, 32'h0, 4'b0010, 1'b1, 2'd1, 32'h0, 32'h0));
        tbl.push_back(mk(4'b1011, 2'b00, 4'h0, 4'h0, 1'b0, 4'h0, 32'h0, 4'b1000, 1'b1, 2'd3, 32'h0, 32'h0));
        tbl.push_back(mk(4'b1011, 2'b00, 4'h0, 4'h0, 1'b0, 4'h0, 32'h0, 4'b0001, 1'b1, 2'd0, 32'h0, 32'h0));
        tbl.push_back(mk(4'b0100, 2'b00, 4'h0, 4'h0, 1'b1, 4'h3, 32'hDEADBEEF, 4'b0100, 1'b1, 2'd2, 32'h0, 32'h0));
        tbl.push_back(mk(4'b0100, 2'b11, 4'h3, 4'h3, 1'b0, 4'h0, 32'h0, 4'b0100, 1'b1, 2'd2, 32'hDEADBEEF, 32'hDEADBEEF));
        tbl.push_back(mk(4'b0000, 2'b11, 4'h3, 4'h3, 1'b0, 4'h0, 32'h0, 4'b0000, 1'b0, 2'd0, 32'h0, 32'h0));
        tbl.push_back(mk(4'b0100, 2'b11, 4'h7, 4'h7, 1'b1, 4'h7, 32'h1234_5678, 4'b0100, 1'b1, 2'd2, FWD, FWD));
        tbl.push_back(mk(4'b0001, 2'b11, 4'h7, 4'h7, 1'b0, 4'h0, 32'h0, 4'b0001, 1'b1, 2'd0, 32'h1234_5678, 32'h1234_5678));
        tbl.push_back(mk(4'b0010, 2'b00, 4'h0, 4'h0, 1'b1, 4'h5, 32'hA5A5A5A5, 4'b0010, 1'b1, 2'd1, 32'h0, 32'h0));
        tbl.push_back(mk(4'b0010, 2'b10, 4'h5, 4'h5, 1'b0, 4'h0, 32'h0, 4'b0010, 1'b1, 2'd1, 32'h0, 32'hA5A5A5A5));
        tbl.push_back(mk(4'b0000, 2'b00, 4'h0, 4'h0, 1'b0, 4'h0, 32'h0, 4'b0000, 1'b0, 2'd0, 32'h0, 32'h0));

        reset_n = 1'b0;
        clr     = 1'b1;
        drive(4'hF, 2'b11, 4'h1, 4'h2, 1'b1, 4'h1, 32'h1);
        step();
        step();
        chk("rst_ready", 32'(req_ready), 32'h0);
        chk("rst_rf_we", 32'(rf_write_en), 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_rsp_id", 32'(rsp_id), 32'h0);
        chk("rst_rdata_0", rsp_rdata_0, 32'h0);
        chk("rst_rdata_1", rsp_rdata_1, 32'h0);
        clr     = 1'b0;
        reset_n = 1'b1;

        foreach (tbl[n]) begin
            drive(tbl[n].v, tbl[n].rd, tbl[n].ra0, tbl[n].ra1, tbl[n].we, tbl[n].wa, tbl[n].wd);
            #1;
            chk($sformatf("vec%0d_ready", n), 32'(req_ready), 32'(tbl[n].ready));
            step();
            chk($sformatf("vec%0d_rsp_valid", n), 32'(rsp_valid), 32'(tbl[n].rv));
            if (tbl[n].rv) begin
                chk($sformatf("vec%0d_rsp_id", n), 32'(rsp_id), 32'(tbl[n].id));
                chk($sformatf("vec%0d_rdata_0", n), rsp_rdata_0, tbl[n].d0);
                chk($sformatf("vec%0d_rdata_1", n), rsp_rdata_1, tbl[n].d1);
            end
        end

        for (int a = 0; a < 16; a++) begin
            drive(4'b0100, 2'b00, 4'h0, 4'h0, 1'b1, 4'(a), 32'(1) << a);
            step();
        end
        for (int a = 0; a < 16; a++) begin
            drive(4'b0100, 2'b11, 4'(a), 4'((a + 1) % 16), 1'b0, 4'h0, 32'h0);
            step();
            chk($sformatf("walk%0d_id", a), 32'(rsp_id), 32'd2);
            chk($sformatf("walk%0d_rdata_0", a), rsp_rdata_0, 32'(1) << a);
            chk($sformatf("walk%0d_rdata_1", a), rsp_rdata_1, 32'(1) << ((a + 1) % 16));
        end

        req_valid    = 4'hF;
        req_read_en  = 8'hFF;
        req_write_en = 4'h0;
        req_wdata    = '0;
        for (int i = 0; i < 4; i++) begin
            req_raddr_0[i*4 +: 4] = 4'(i);
            req_raddr_1[i*4 +: 4] = 4'(i + 4);
            req_waddr[i*4 +: 4]   = 4'(i + 8);
        end
        for (int k = 0; k < 4; k++) begin
            int g;
            g = (3 + k) % 4;
            #1;
            chk($sformatf("mux%0d_ready", k), 32'(req_ready), 32'(1) << g);
            chk($sformatf("mux%0d_raddr_0", k), 32'(rf_raddr_0), 32'(g));
            chk($sformatf("mux%0d_raddr_1", k), 32'(rf_raddr_1), 32'(g + 4));
            chk($sformatf("mux%0d_waddr", k), 32'(rf_waddr), 32'(g + 8));
            chk($sformatf("mux%0d_read_en", k), 32'(rf_read_en), 32'h3);
            step();
            chk($sformatf("mux%0d_rsp_id", k), 32'(rsp_id), 32'(g));
            chk($sformatf("mux%0d_rdata_0", k), rsp_rdata_0, 32'(1) << g);
            chk($sformatf("mux%0d_rdata_1", k), rsp_rdata_1, 32'(1) << (g + 4));
        end

        drive(4'b0000, 2'b11, 4'h9, 4'h9, 1'b1, 4'h9, 32'h55);
        #1;
        chk("idle_read_en", 32'(rf_read_en), 32'h0);
        chk("idle_write_en", 32'(rf_write_en), 32'h0);
        chk("idle_raddr_0", 32'(rf_raddr_0), 32'h0);
        chk("idle_wdata", rf_wdata, 32'h0);
        step();

        drive(4'b0010, 2'b00, 4'h0, 4'h0, 1'b0, 4'h0, 32'h0);
        step();
        chk("pre_rst_rsp_valid", 32'(rsp_valid), 32'h1);
        reset_n = 1'b0;
        drive(4'b0010, 2'b00, 4'h0, 4'h0, 1'b1, 4'hF, 32'hFFFF0000);
        #1;
        chk("mid_rst_ready", 32'(req_ready), 32'h0);
        chk("mid_rst_rf_we", 32'(rf_write_en), 32'h0);
        step();
        chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'h0);
        reset_n = 1'b1;
        drive(4'hF, 2'b00, 4'h0, 4'h0, 1'b0, 4'h0, 32'h0);
        #1;
        chk("post_rst_ready", 32'(req_ready), 32'h1);
        step();
        chk("post_rst_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("post_rst_rsp_id", 32'(rsp_id), 32'h0);
        drive(4'b0100, 2'b11, 4'hF, 4'hF, 1'b0, 4'h0, 32'h0);
        step();
        chk("post_rst_reg15", rsp_rdata_0, 32'h0000_8000);
        drive(4'b0000, 2'b00, 4'h0, 4'h0, 1'b0, 4'h0, 32'h0);
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
